// File: rtl/axi_default_slave_pkg.sv
// Shared AXI definitions for the default-slave endpoint.
// Holds the bus field widths, the AXI response codes, and the state
// encodings for the write and read channel FSMs.
package axi_default_slave_pkg;

  localparam int AXI_IDS_BITS  = 8;
  localparam int AXI_ADDR_BITS = 32;
  localparam int AXI_LEN_BITS  = 4;
  localparam int AXI_SIZE_BITS = 3;
  localparam int AXI_DATA_BITS = 32;
  localparam int AXI_STRB_BITS = 4;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } axi_resp_e;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } wr_state_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_e;

endpackage

// File: rtl/axi_default_rd_ch.sv
// Read channel of the default slave: accepts one AR at a time and returns
// ARLen+1 beats of constant fill data with the error response code.
//
// state  | meaning
// R_IDLE | ARReady high, waiting for an address
// R_DATA | RValid high, streaming beats until the RLast handshake
//
// Ports:
//   aclk_i, aresetn_i    clock, async active-low reset
//   arid_i, arlen_i      read address ID and burst length minus one
//   arvalid_i/arready_o  AR handshake
//   rid_o, rdata_o       latched ID, fill data
//   rresp_o, rlast_o     response code, final-beat flag
//   rvalid_o/rready_i    R handshake
module axi_default_rd_ch
  import axi_default_slave_pkg::*;
#(
  parameter logic [1:0]               RESP_CODE  = RESP_DECERR,
  parameter logic [AXI_DATA_BITS-1:0] RDATA_FILL = '0
) (
  input  logic                     aclk_i,
  input  logic                     aresetn_i,
  input  logic [AXI_IDS_BITS-1:0]  arid_i,
  input  logic [AXI_LEN_BITS-1:0]  arlen_i,
  input  logic                     arvalid_i,
  output logic                     arready_o,
  output logic [AXI_IDS_BITS-1:0]  rid_o,
  output logic [AXI_DATA_BITS-1:0] rdata_o,
  output logic [1:0]               rresp_o,
  output logic                     rlast_o,
  output logic                     rvalid_o,
  input  logic                     rready_i
);

  localparam logic [AXI_LEN_BITS-1:0] CNT_ONE = {{(AXI_LEN_BITS-1){1'b0}}, 1'b1};

  rd_state_e                 state_q;
  logic [AXI_IDS_BITS-1:0]   id_q;
  logic [AXI_LEN_BITS-1:0]   len_q;
  logic [AXI_LEN_BITS-1:0]   cnt_q;

  always_ff @(posedge aclk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      state_q <= R_IDLE;
      id_q    <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        R_IDLE: begin
          if (arvalid_i) begin
            id_q    <= arid_i;
            len_q   <= arlen_i;
            cnt_q   <= '0;
            state_q <= R_DATA;
          end
        end
        R_DATA: begin
          if (rready_i) begin
            // The count may wrap on the final beat of a 16-beat burst; it is
            // cleared on the next AR so the wrapped value is never observed.
            cnt_q <= cnt_q + CNT_ONE;
            if (cnt_q == len_q) state_q <= R_IDLE;
          end
        end
        default: state_q <= R_IDLE;
      endcase
    end
  end

  assign arready_o = (state_q == R_IDLE);
  assign rvalid_o  = (state_q == R_DATA);
  assign rlast_o   = (state_q == R_DATA) && (cnt_q == len_q);
  assign rid_o     = id_q;
  assign rdata_o   = RDATA_FILL;
  assign rresp_o   = RESP_CODE;

endmodule

// File: rtl/axi_default_slave.sv
// AXI4 default slave: terminates every transaction that falls outside the
// mapped memory windows with an error response so the master never hangs.
// The write FSM lives here; the read FSM is in axi_default_rd_ch. The two
// channels run independently, each with at most one transaction in flight.
//
// state  | meaning
// W_IDLE | AWReady high, waiting for a write address
// W_DATA | WReady high, discarding beats until WLast
// W_RESP | BValid high, holding the response until BReady
//
// Ports:
//   ACLK, ARESETn         clock, async active-low reset
//   S_AW*                 write address channel (only ID is used)
//   S_W*                  write data channel (data discarded, WLast used)
//   S_B*                  write response channel
//   S_AR*                 read address channel (ID and Len used)
//   S_R*                  read data channel
module axi_default_slave
  import axi_default_slave_pkg::*;
#(
  parameter logic [1:0]               RESP_CODE  = RESP_DECERR,
  parameter logic [AXI_DATA_BITS-1:0] RDATA_FILL = 32'h0000_0000
) (
  input  logic                     ACLK,
  input  logic                     ARESETn,
  input  logic [AXI_IDS_BITS-1:0]  S_AWID,
  input  logic [AXI_ADDR_BITS-1:0] S_AWAddr,
  input  logic [AXI_LEN_BITS-1:0]  S_AWLen,
  input  logic [AXI_SIZE_BITS-1:0] S_AWSize,
  input  logic [1:0]               S_AWBurst,
  input  logic                     S_AWValid,
  output logic                     S_AWReady,
  input  logic [AXI_DATA_BITS-1:0] S_WData,
  input  logic [AXI_STRB_BITS-1:0] S_WStrb,
  input  logic                     S_WLast,
  input  logic                     S_WValid,
  output logic                     S_WReady,
  output logic [AXI_IDS_BITS-1:0]  S_BID,
  output logic [1:0]               S_BResp,
  output logic                     S_BValid,
  input  logic                     S_BReady,
  input  logic [AXI_IDS_BITS-1:0]  S_ARID,
  input  logic [AXI_ADDR_BITS-1:0] S_ARAddr,
  input  logic [AXI_LEN_BITS-1:0]  S_ARLen,
  input  logic [AXI_SIZE_BITS-1:0] S_ARSize,
  input  logic [1:0]               S_ARBurst,
  input  logic                     S_ARValid,
  output logic                     S_ARReady,
  output logic [AXI_IDS_BITS-1:0]  S_RID,
  output logic [AXI_DATA_BITS-1:0] S_RData,
  output logic [1:0]               S_RResp,
  output logic                     S_RLast,
  output logic                     S_RValid,
  input  logic                     S_RReady
);

  wr_state_e               w_state_q;
  logic [AXI_IDS_BITS-1:0] bid_q;

  // Fields that carry no meaning for an endpoint that always errors.
  logic unused_inputs;
  assign unused_inputs = ^{S_AWAddr, S_AWLen, S_AWSize, S_AWBurst,
                           S_WData, S_WStrb, S_ARAddr, S_ARSize, S_ARBurst};

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      w_state_q <= W_IDLE;
      bid_q     <= '0;
    end else begin
      case (w_state_q)
        W_IDLE: begin
          if (S_AWValid) begin
            bid_q     <= S_AWID;
            w_state_q <= W_DATA;
          end
        end
        W_DATA: begin
          // Burst ends on WLast alone; a mismatched AWLen cannot wedge us.
          if (S_WValid && S_WLast) w_state_q <= W_RESP;
        end
        W_RESP: begin
          if (S_BReady) w_state_q <= W_IDLE;
        end
        default: w_state_q <= W_IDLE;
      endcase
    end
  end

  assign S_AWReady = (w_state_q == W_IDLE);
  assign S_WReady  = (w_state_q == W_DATA);
  assign S_BValid  = (w_state_q == W_RESP);
  assign S_BID     = bid_q;
  assign S_BResp   = RESP_CODE;

  axi_default_rd_ch #(
    .RESP_CODE  (RESP_CODE),
    .RDATA_FILL (RDATA_FILL)
  ) u_rd_ch (
    .aclk_i    (ACLK),
    .aresetn_i (ARESETn),
    .arid_i    (S_ARID),
    .arlen_i   (S_ARLen),
    .arvalid_i (S_ARValid),
    .arready_o (S_ARReady),
    .rid_o     (S_RID),
    .rdata_o   (S_RData),
    .rresp_o   (S_RResp),
    .rlast_o   (S_RLast),
    .rvalid_o  (S_RValid),
    .rready_i  (S_RReady)
  );

endmodule

// File: tb/tb_axi_default_slave.sv
module tb_axi_default_slave;

  logic        ACLK;
  logic        ARESETn;
  logic [7:0]  S_AWID;
  logic [31:0] S_AWAddr;
  logic [3:0]  S_AWLen;
  logic [2:0]  S_AWSize;
  logic [1:0]  S_AWBurst;
  logic        S_AWValid;
  logic        S_AWReady;
  logic [31:0] S_WData;
  logic [3:0]  S_WStrb;
  logic        S_WLast;
  logic        S_WValid;
  logic        S_WReady;
  logic [7:0]  S_BID;
  logic [1:0]  S_BResp;
  logic        S_BValid;
  logic        S_BReady;
  logic [7:0]  S_ARID;
  logic [31:0] S_ARAddr;
  logic [3:0]  S_ARLen;
  logic [2:0]  S_ARSize;
  logic [1:0]  S_ARBurst;
  logic        S_ARValid;
  logic        S_ARReady;
  logic [7:0]  S_RID;
  logic [31:0] S_RData;
  logic [1:0]  S_RResp;
  logic        S_RLast;
  logic        S_RValid;
  logic        S_RReady;

  localparam logic [1:0]  EXP_RESP = 2'b11;
  localparam logic [31:0] EXP_DATA = 32'h0000_0000;

  int total = 0;
  int bad   = 0;

  axi_default_slave dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .S_AWID(S_AWID), .S_AWAddr(S_AWAddr), .S_AWLen(S_AWLen), .S_AWSize(S_AWSize),
    .S_AWBurst(S_AWBurst), .S_AWValid(S_AWValid), .S_AWReady(S_AWReady),
    .S_WData(S_WData), .S_WStrb(S_WStrb), .S_WLast(S_WLast),
    .S_WValid(S_WValid), .S_WReady(S_WReady),
    .S_BID(S_BID), .S_BResp(S_BResp), .S_BValid(S_BValid), .S_BReady(S_BReady),
    .S_ARID(S_ARID), .S_ARAddr(S_ARAddr), .S_ARLen(S_ARLen), .S_ARSize(S_ARSize),
    .S_ARBurst(S_ARBurst), .S_ARValid(S_ARValid), .S_ARReady(S_ARReady),
    .S_RID(S_RID), .S_RData(S_RData), .S_RResp(S_RResp), .S_RLast(S_RLast),
    .S_RValid(S_RValid), .S_RReady(S_RReady)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  task automatic tick;
    @(posedge ACLK);
    #1;
  endtask

  // Read transaction against the reference rule: len+1 beats, fill data,
  // error response, echoed ID, RLast only on the final beat, then idle.
  // mode 0: RReady always 1, mode 1: toggles 1/0, mode 2: random.
  task automatic do_read(input logic [7:0] id, input logic [3:0] len, input int mode);
    int  beat;
    int  cyc;
    bit  done;
    bit  rr;
    cyc = 0;
    while (!S_ARReady && cyc < 50) begin tick; cyc++; end
    total++;
    if (S_ARReady !== 1'b1) begin bad++; $display("FAIL rd_ar_wait got=%b exp=1", S_ARReady); end
    S_ARValid = 1'b1; S_ARID = id; S_ARLen = len;
    S_ARAddr = $urandom; S_ARSize = 3'd2; S_ARBurst = 2'b01;
    tick;
    S_ARValid = 1'b0; S_ARID = $urandom; S_ARLen = $urandom;
    beat = 0; done = 0; cyc = 0;
    while (!done && cyc < 200) begin
      total++;
      if (S_RValid !== 1'b1) begin
        bad++; $display("FAIL rd_rvalid beat=%0d got=%b exp=1", beat, S_RValid);
      end else if (S_RID !== id || S_RData !== EXP_DATA || S_RResp !== EXP_RESP ||
                   S_RLast !== (beat == int'(len))) begin
        bad++;
        $display("FAIL rd_beat beat=%0d got id=%h data=%h resp=%b last=%b exp id=%h data=%h resp=%b last=%b",
                 beat, S_RID, S_RData, S_RResp, S_RLast, id, EXP_DATA, EXP_RESP, (beat == int'(len)));
      end
      case (mode)
        0:       rr = 1'b1;
        1:       rr = (cyc % 2 == 0);
        default: rr = ($urandom_range(0, 1) == 1);
      endcase
      S_RReady = rr;
      tick;
      cyc++;
      if (rr) begin
        if (beat == int'(len)) done = 1'b1;
        beat++;
      end
    end
    S_RReady = 1'b0;
    total++;
    if (!done) begin bad++; $display("FAIL rd_timeout got_beats=%0d exp=%0d", beat, int'(len) + 1); end
    total++;
    if (S_RValid !== 1'b0 || S_ARReady !== 1'b1) begin
      bad++; $display("FAIL rd_end got rvalid=%b arready=%b exp rvalid=0 arready=1", S_RValid, S_ARReady);
    end
  endtask

  // Write transaction: nbeats W beats end with WLast; B carries the AW ID.
  task automatic do_write(input logic [7:0] id, input int nbeats, input logic [3:0] awlen,
                          input int bdelay, input bit early, input bit try_aw);
    int cyc;
    int sent;
    bit wv;
    if (early) begin
      S_WValid = 1'b1; S_WLast = (nbeats == 1); S_WData = $urandom;
      repeat (3) begin
        tick;
        total++;
        if (S_WReady !== 1'b0) begin bad++; $display("FAIL wr_early_wready got=%b exp=0", S_WReady); end
      end
    end
    cyc = 0;
    while (!S_AWReady && cyc < 50) begin tick; cyc++; end
    total++;
    if (S_AWReady !== 1'b1) begin bad++; $display("FAIL wr_aw_wait got=%b exp=1", S_AWReady); end
    S_AWValid = 1'b1; S_AWID = id; S_AWLen = awlen;
    S_AWAddr = $urandom; S_AWSize = 3'd2; S_AWBurst = 2'b01;
    tick;
    S_AWValid = 1'b0; S_AWID = $urandom;
    sent = 0; cyc = 0;
    while (sent < nbeats && cyc < 200) begin
      total++;
      if (S_WReady !== 1'b1 || S_BValid !== 1'b0) begin
        bad++; $display("FAIL wr_data_phase got wready=%b bvalid=%b exp wready=1 bvalid=0", S_WReady, S_BValid);
      end
      wv = early ? 1'b1 : ($urandom_range(0, 3) != 0);
      S_WValid = wv; S_WData = $urandom; S_WStrb = $urandom; S_WLast = (sent == nbeats - 1);
      tick;
      cyc++;
      if (wv) sent++;
    end
    S_WValid = 1'b0; S_WLast = 1'b0;
    for (int k = 0; k < bdelay; k++) begin
      total++;
      if (S_BValid !== 1'b1 || S_BID !== id || S_BResp !== EXP_RESP || S_AWReady !== 1'b0 || S_WReady !== 1'b0) begin
        bad++;
        $display("FAIL wr_b_stall cyc=%0d got bvalid=%b bid=%h bresp=%b awready=%b wready=%b exp 1 %h %b 0 0",
                 k, S_BValid, S_BID, S_BResp, S_AWReady, S_WReady, id, EXP_RESP);
      end
      S_BReady = 1'b0;
      if (try_aw) begin S_AWValid = 1'b1; S_AWID = id ^ 8'hff; end
      tick;
    end
    S_AWValid = 1'b0;
    total++;
    if (S_BValid !== 1'b1 || S_BID !== id || S_BResp !== EXP_RESP) begin
      bad++; $display("FAIL wr_b got bvalid=%b bid=%h bresp=%b exp 1 %h %b", S_BValid, S_BID, S_BResp, id, EXP_RESP);
    end
    S_BReady = 1'b1;
    tick;
    S_BReady = 1'b0;
    total++;
    if (S_BValid !== 1'b0 || S_AWReady !== 1'b1) begin
      bad++; $display("FAIL wr_end got bvalid=%b awready=%b exp 0 1", S_BValid, S_AWReady);
    end
  endtask

  task automatic test_reset;
    ARESETn = 1'b0;
    S_AWID = '0; S_AWAddr = '0; S_AWLen = '0; S_AWSize = '0; S_AWBurst = '0; S_AWValid = 1'b0;
    S_WData = '0; S_WStrb = '0; S_WLast = 1'b0; S_WValid = 1'b0; S_BReady = 1'b0;
    S_ARID = '0; S_ARAddr = '0; S_ARLen = '0; S_ARSize = '0; S_ARBurst = '0; S_ARValid = 1'b0;
    S_RReady = 1'b0;
    #3;
    total++;
    if (S_AWReady !== 1'b1 || S_WReady !== 1'b0 || S_BValid !== 1'b0 || S_BID !== 8'h00 ||
        S_ARReady !== 1'b1 || S_RValid !== 1'b0 || S_RID !== 8'h00 || S_RLast !== 1'b0) begin
      bad++;
      $display("FAIL reset got awr=%b wr=%b bv=%b bid=%h arr=%b rv=%b rid=%h rl=%b exp 1 0 0 00 1 0 00 0",
               S_AWReady, S_WReady, S_BValid, S_BID, S_ARReady, S_RValid, S_RID, S_RLast);
    end
    tick; tick;
    ARESETn = 1'b1;
    tick;
    total++;
    if (S_AWReady !== 1'b1 || S_ARReady !== 1'b1 || S_BValid !== 1'b0 || S_RValid !== 1'b0) begin
      bad++; $display("FAIL post_reset got awr=%b arr=%b bv=%b rv=%b exp 1 1 0 0", S_AWReady, S_ARReady, S_BValid, S_RValid);
    end
  endtask

  task automatic test_write_latency;
    S_AWValid = 1'b1; S_AWID = 8'h13; S_AWLen = 4'd0;
    S_WValid = 1'b1; S_WLast = 1'b1; S_WData = $urandom; S_BReady = 1'b1;
    tick;
    S_AWValid = 1'b0;
    total++;
    if (S_WReady !== 1'b1 || S_BValid !== 1'b0 || S_AWReady !== 1'b0) begin
      bad++; $display("FAIL lat_n1 got wready=%b bvalid=%b awready=%b exp 1 0 0", S_WReady, S_BValid, S_AWReady);
    end
    tick;
    S_WValid = 1'b0; S_WLast = 1'b0;
    total++;
    if (S_BValid !== 1'b1 || S_BID !== 8'h13 || S_BResp !== EXP_RESP || S_WReady !== 1'b0) begin
      bad++; $display("FAIL lat_n2 got bvalid=%b bid=%h bresp=%b wready=%b exp 1 13 11 0", S_BValid, S_BID, S_BResp, S_WReady);
    end
    tick;
    S_BReady = 1'b0;
    total++;
    if (S_BValid !== 1'b0 || S_AWReady !== 1'b1) begin
      bad++; $display("FAIL lat_done got bvalid=%b awready=%b exp 0 1", S_BValid, S_AWReady);
    end
  endtask

  task automatic test_read_burst;
    do_read(8'h25, 4'd3, 0);
  endtask

  task automatic test_read_stall_long;
    do_read(8'h7a, 4'd15, 1);
  endtask

  task automatic test_concurrent;
    fork
      do_write(8'h01, 2, 4'd1, 0, 1'b0, 1'b0);
      do_read(8'h02, 4'd1, 0);
    join
  endtask

  task automatic test_w_before_aw_b_stall;
    do_write(8'h5e, 1, 4'd0, 5, 1'b1, 1'b1);
  endtask

  task automatic test_reset_mid_burst;
    S_ARValid = 1'b1; S_ARID = 8'h3c; S_ARLen = 4'd3;
    tick;
    S_ARValid = 1'b0;
    S_RReady = 1'b1;
    tick; tick;
    total++;
    if (S_RValid !== 1'b1 || S_RLast !== 1'b0 || S_RID !== 8'h3c) begin
      bad++; $display("FAIL rst_mid_pre got rvalid=%b rlast=%b rid=%h exp 1 0 3c", S_RValid, S_RLast, S_RID);
    end
    #2 ARESETn = 1'b0;
    #1;
    total++;
    if (S_RValid !== 1'b0 || S_RLast !== 1'b0 || S_RID !== 8'h00 || S_ARReady !== 1'b1) begin
      bad++; $display("FAIL rst_mid_async got rvalid=%b rlast=%b rid=%h arready=%b exp 0 0 00 1",
                      S_RValid, S_RLast, S_RID, S_ARReady);
    end
    S_RReady = 1'b0;
    tick;
    ARESETn = 1'b1;
    tick;
    do_read(8'h4d, 4'd3, 0);
  endtask

  task automatic test_random;
    for (int i = 0; i < 8; i++) begin
      logic [7:0] wid;
      logic [7:0] rid;
      int         nb;
      logic [3:0] awl;
      logic [3:0] arl;
      int         bd;
      wid = $urandom; rid = $urandom;
      nb  = $urandom_range(1, 6);
      awl = $urandom;
      arl = $urandom;
      bd  = $urandom_range(0, 3);
      fork
        do_write(wid, nb, awl, bd, 1'b0, 1'b0);
        do_read(rid, arl, 2);
      join
    end
  endtask

  initial begin
    test_reset();
    test_write_latency();
    test_read_burst();
    test_read_stall_long();
    test_concurrent();
    test_w_before_aw_b_stall();
    test_reset_mid_burst();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
